// File: rtl/writeback_commit_pkg.sv
// Shared types for the writeback/commit stage: queue entry layout and pointer width.
package writeback_commit_pkg;

    localparam int unsigned WB_XLEN  = 64;
    localparam int unsigned WB_DEPTH = 4;
    localparam int unsigned WB_PTR_W = $clog2(WB_DEPTH);

    typedef logic [WB_PTR_W-1:0] wb_ptr_t;

    typedef struct packed {
        logic [WB_XLEN-1:0] pc;
        logic [31:0]        instr;
        logic               wen;
        logic [4:0]         dst;
        logic [WB_XLEN-1:0] data;
        logic               excep;
    } wb_entry_t;

endpackage

// File: rtl/writeback_commit_fwd_lookup.sv
// Youngest-match register forwarding search; candidates are ordered oldest (index 0) to youngest.
module wb_fwd_lookup #(
    parameter int unsigned NCAND = 6,
    parameter int unsigned XLEN  = 64
) (
    input  logic [4:0]            addr,
    input  logic [NCAND-1:0]      candValid,
    input  logic [NCAND*5-1:0]    candDst,
    input  logic [NCAND*XLEN-1:0] candData,
    output logic                  hit,
    output logic [XLEN-1:0]       data
);

    always_comb begin
        hit  = 1'b0;
        data = '0;
        // Later (younger) matches overwrite earlier ones.
        for (int unsigned i = 0; i < NCAND; i++) begin
            if (addr != 5'd0 && candValid[i] && candDst[i*5 +: 5] == addr) begin
                hit  = 1'b1;
                data = candData[i*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/writeback_commit.sv
// Buffered writeback/commit stage: in-order queue, NPORTS registered retire lanes, flush/exception squash.
// Optional forwarding lookup enabled by defining WB_FWD_EN.
module writeback_commit
    import writeback_commit_pkg::*;
#(
    parameter int unsigned DEPTH  = WB_DEPTH,
    parameter int unsigned NPORTS = 2,
    parameter int unsigned XLEN   = WB_XLEN
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [XLEN-1:0]        in_pc,
    input  logic [31:0]            in_instr,
    input  logic                   in_wen,
    input  logic [4:0]             in_dst,
    input  logic [XLEN-1:0]        in_data,
    input  logic                   in_excep,
    input  logic                   stall,
    input  logic                   flush,
    output logic [NPORTS-1:0]      rf_wen,
    output logic [NPORTS*5-1:0]    rf_waddr,
    output logic [NPORTS*XLEN-1:0] rf_wdata,
    output logic [NPORTS-1:0]      cm_valid,
    output logic [NPORTS*XLEN-1:0] cm_pc,
    output logic [NPORTS*32-1:0]   cm_instr,
    output logic                   excep_out,
    output logic [XLEN-1:0]        excep_pc,
    output logic [63:0]            instret,
    input  logic [4:0]             fwd_addr,
    output logic                   fwd_hit,
    output logic [XLEN-1:0]        fwd_data
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [CntW-1:0] cnt_t;

    wb_entry_t         mem [DEPTH];
    ptr_t              head, tail;
    cnt_t              count;
    wb_entry_t         laneQ [NPORTS];
    logic [NPORTS-1:0] laneValidQ;
    logic              excepQ;
    logic [XLEN-1:0]   excepPcQ;
    logic [63:0]       instretQ;

    wb_entry_t         inEntry;
    wb_entry_t         laneD [NPORTS];
    logic [NPORTS-1:0] laneValidD;
    logic              doRetire, excepHit, push, stopped;
    cnt_t              numRet;
    logic [XLEN-1:0]   excepPcD;

    assign in_ready = reset && (count != cnt_t'(DEPTH));
    assign doRetire = !stall && !flush;
    assign push     = in_valid && in_ready && !flush && !excepHit;

    always_comb begin
        inEntry       = '0;
        inEntry.pc    = WB_XLEN'(in_pc);
        inEntry.instr = in_instr;
        inEntry.wen   = in_wen;
        inEntry.dst   = in_dst;
        inEntry.data  = WB_XLEN'(in_data);
        inEntry.excep = in_excep;
    end

    // Select up to NPORTS oldest entries; stop after the first excepting one.
    always_comb begin
        stopped    = 1'b0;
        excepHit   = 1'b0;
        excepPcD   = '0;
        numRet     = '0;
        laneValidD = '0;
        for (int unsigned i = 0; i < NPORTS; i++) begin
            laneD[i] = '0;
            if (doRetire && !stopped && cnt_t'(i) < count) begin
                laneD[i]      = mem[head + ptr_t'(i)];
                laneValidD[i] = 1'b1;
                numRet        = numRet + cnt_t'(1);
                if (laneD[i].excep) begin
                    stopped  = 1'b1;
                    excepHit = 1'b1;
                    excepPcD = XLEN'(laneD[i].pc);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[tail] <= inEntry;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            laneValidQ <= '0;
            for (int unsigned i = 0; i < NPORTS; i++) laneQ[i] <= '0;
            excepQ     <= 1'b0;
            excepPcQ   <= '0;
            instretQ   <= '0;
        end else begin
            laneValidQ <= laneValidD;
            laneQ      <= laneD;
            excepQ     <= excepHit;
            excepPcQ   <= excepPcD;
            instretQ   <= instretQ + 64'(numRet);
            if (flush || excepHit) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                head  <= head + ptr_t'(numRet);
                tail  <= tail + ptr_t'(push);
                count <= count + cnt_t'(push) - numRet;
            end
        end
    end

    always_comb begin
        rf_wen   = '0;
        rf_waddr = '0;
        rf_wdata = '0;
        cm_pc    = '0;
        cm_instr = '0;
        for (int unsigned i = 0; i < NPORTS; i++) begin
            rf_wen[i]             = laneValidQ[i] && laneQ[i].wen && laneQ[i].dst != 5'd0 && !laneQ[i].excep;
            rf_waddr[i*5 +: 5]    = laneQ[i].dst;
            rf_wdata[i*XLEN +: XLEN] = XLEN'(laneQ[i].data);
            cm_pc[i*XLEN +: XLEN] = XLEN'(laneQ[i].pc);
            cm_instr[i*32 +: 32]  = laneQ[i].instr;
        end
    end

    assign cm_valid  = laneValidQ;
    assign excep_out = excepQ;
    assign excep_pc  = excepPcQ;
    assign instret   = instretQ;

`ifdef WB_FWD_EN
    localparam int unsigned NCand = NPORTS + DEPTH;
    logic [NCand-1:0]      candValid;
    logic [NCand*5-1:0]    candDst;
    logic [NCand*XLEN-1:0] candData;
    wb_entry_t             qEnt;

    // Lanes first (older), then queue entries from head (older to younger).
    always_comb begin
        candValid = '0;
        candDst   = '0;
        candData  = '0;
        qEnt      = '0;
        for (int unsigned i = 0; i < NPORTS; i++) begin
            candValid[i]             = laneValidQ[i] && laneQ[i].wen;
            candDst[i*5 +: 5]        = laneQ[i].dst;
            candData[i*XLEN +: XLEN] = XLEN'(laneQ[i].data);
        end
        for (int unsigned j = 0; j < DEPTH; j++) begin
            qEnt = mem[head + ptr_t'(j)];
            candValid[NPORTS+j]             = (cnt_t'(j) < count) && qEnt.wen;
            candDst[(NPORTS+j)*5 +: 5]      = qEnt.dst;
            candData[(NPORTS+j)*XLEN +: XLEN] = XLEN'(qEnt.data);
        end
    end

    wb_fwd_lookup #(
        .NCAND(NCand),
        .XLEN (XLEN)
    ) uFwdLookup (
        .addr     (fwd_addr),
        .candValid(candValid),
        .candDst  (candDst),
        .candData (candData),
        .hit      (fwd_hit),
        .data     (fwd_data)
    );
`else
    logic unusedFwd;
    assign unusedFwd = ^fwd_addr;
    assign fwd_hit   = 1'b0;
    assign fwd_data  = '0;
`endif

endmodule

// File: doc/writeback_commit.md
Name: writeback_commit

Overview:
- Parametrised writeback stage with buffering, placed between the memory stage and the register file and commit/difftest interface.
- Holds completed instructions in a DEPTH-entry in-order queue and retires up to NPORTS per cycle through registered register-file write lanes.
- Handles exception-triggered and external flushes.
- Keeps a retired-instruction counter and provides a register-forwarding lookup over in-flight results.

Parameters:
- DEPTH, 4, queue entries; power of 2, at least 2.
- NPORTS, 2, commit lanes per cycle; 1 ≤ NPORTS ≤ DEPTH.
- XLEN, 64, data and PC width.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low; 0 = in reset.
- in_valid  input  1  memory-stage result valid.
- in_ready  output  1  queue can accept.
- in_pc  input  XLEN  instruction PC.
- in_instr  input  32  raw instruction.
- in_wen  input  1  writes an integer register.
- in_dst  input  5  destination register.
- in_data  input  XLEN  write data.
- in_excep  input  1  instruction raised an exception.
- stall  input  1  hold commit; no dequeue.
- flush  input  1  discard all queued entries.
- rf_wen  output  NPORTS  per-lane register-file write enable.
- rf_waddr  output  NPORTS*5  per-lane register.
- rf_wdata  output  NPORTS*XLEN  per-lane data.
- cm_valid  output  NPORTS  per-lane retire valid; lane 0 is oldest.
- cm_pc  output  NPORTS*XLEN  per-lane PC.
- cm_instr  output  NPORTS*32  per-lane instruction.
- excep_out  output  1  one-cycle pulse when an excepting instruction retires.
- excep_pc  output  XLEN  PC of that instruction.
- instret  output  64  retired-instruction count.
- fwd_addr  input  5  forwarding query register.
- fwd_hit  output  1  query matched.
- fwd_data  output  XLEN  youngest matching data.

Behaviour:
- Reset values: all outputs 0; queue empty; head, tail and count 0; in_ready 0 while reset is asserted.
- Enqueue:
  - Handshake fires when in_valid && in_ready.
  - in_ready = (count != DEPTH), computed from registered count only. No combinational in_valid→in_ready path.
  - Data is captured on the handshake edge.
- Dequeue:
  - When stall = 0, on each edge dequeue k = min(count, NPORTS) oldest entries in order.
  - Lane i receives entry head+i.
  - All lane outputs are registered. An entry accepted at edge E0 can appear on cm_valid no earlier than the cycle after edge E1.
  - When stall = 1, lane outputs clear to 0 on the next edge (no duplicate retire), and the queue holds.
- Write enable: rf_wen[i] = cm_valid[i] && wen && dst != 0. An entry with dst = 0 still retires.
- Exceptions:
  - If an entry with excep is selected at lane j, only lanes 0..j retire. That entry's rf_wen is forced 0.
  - excep_out pulses with excep_pc.
  - All younger queued entries are discarded on the same edge. A same-edge enqueue is also dropped.
- flush:
  - On the edge, count goes to 0 and nothing retires; lane outputs clear.
  - flush overrides stall and the enqueue handshake.
- Simultaneous enqueue and dequeue: count_next = count + push - k. A full queue accepts nothing that cycle, because in_ready is from the registered count.
- Pointers wrap modulo DEPTH.
- instret increments by the number of cm_valid lanes set, including the excepting one. It wraps at 2^64.
- Reset asserted mid-operation clears everything asynchronously. Deassertion takes effect at the next clk edge.

Optional Feature:
- WB_FWD_EN defined:
  - fwd_hit/fwd_data are combinational over the registered lane outputs and the valid queue entries.
  - Candidates need wen = 1, dst == fwd_addr, and fwd_addr != 0.
  - The youngest match wins; queue entries are younger than lane outputs.
- WB_FWD_EN undefined: fwd_hit and fwd_data tied to 0; the lookup logic is absent.

Decomposition:
- Shared package (pipes), two items:
  - wb_entry_t struct: pc, instr, wen, dst, data, excep.
  - Localparam type for queue pointer width, $clog2(DEPTH).
- One sub-module: wb_fwd_lookup, the youngest-match priority search, instantiated only under WB_FWD_EN.

Test Plan:
1. Reset release, then push three entries to x5, x6, x0 (data 0x11, 0x22, 0x33) with NPORTS = 2:
   - First retire cycle: lanes 0 and 1 retire, rf_wen = 2'b11.
   - Next cycle: lane 0 retires with rf_wen[0] = 0.
   - instret = 3.
2. Fill all 4 entries with stall = 1:
   - in_ready = 0 and the fifth push is not accepted.
   - Release stall: 2 retire per cycle for 2 cycles; in_ready returns 1 one cycle after the first dequeue.
3. Queue holds A, B(excep), C, D:
   - Retire cycle: A and B valid, B's rf_wen = 0, excep_out = 1, excep_pc = B.pc.
   - C and D never retire; count = 0.
4. Assert flush together with a valid push while 3 entries are queued:
   - Next cycle count = 0 and cm_valid = 0; the pushed entry never retires.
5. WB_FWD_EN: queue holds x7 = 0xA (older) and x7 = 0xB (younger).
   - fwd_addr = 7 → fwd_hit = 1, fwd_data = 0xB.
   - fwd_addr = 0 → fwd_hit = 0.
6. Assert reset low mid-stream with 2 entries queued:
   - All outputs become 0 immediately, without waiting for an edge.
   - After release the queue is empty and instret = 0.
